// File: rtl/decoder_onehot_scan_if.sv
// Select-bus bundle for decoder_onehot_scan: control/address in, registered selects out.
interface decoder_onehot_scan_if #(
    parameter int unsigned AW = 3
);
    logic              en;
    logic              mode;
    logic [AW-1:0]     a;
    logic [2**AW-1:0]  y;
    logic [AW-1:0]     idx;
    logic              wrap;

    modport master (
        output en,
        output mode,
        output a,
        input  y,
        input  idx,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  a,
        output y,
        output idx,
        output wrap
    );
endinterface

// File: rtl/decoder_onehot_scan.sv
// Registered N-to-2^N one-hot decoder: direct address decode, or a prescaled scan
// that steps the select through LIMIT slots holding each for DIV clocks.
module decoder_onehot_scan #(
    parameter int unsigned AW    = 3,
    parameter int unsigned DIV   = 4,
    parameter int unsigned LIMIT = 2**AW
) (
    input logic                  clk,
    input logic                  rst,
    decoder_onehot_scan_if.slave bus
);
    localparam int unsigned NY = 2**AW;
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
    localparam logic [AW-1:0] IdxMax = AW'(LIMIT - 1);

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [NY-1:0]   y_q;
    logic [AW-1:0]   idx_q;
    logic            wrap_q;

    function automatic logic [NY-1:0] onehot(input logic [AW-1:0] i);
        logic [NY-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        state_d = StIdle;
        if (bus.en) begin
            state_d = bus.mode ? StScan : StDirect;
        end
    end

    // Outputs are registered from the next state, so a mode change shows on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_d)
                StDirect: begin
                    y_q    <= onehot(bus.a);
                    idx_q  <= bus.a;
                    wrap_q <= 1'b0;
                    cnt_q  <= '0;
                end
                StScan: begin
                    if (state_q != StScan) begin
                        cnt_q  <= '0;
                        idx_q  <= '0;
                        y_q    <= onehot('0);
                        wrap_q <= 1'b0;
                    end else if (cnt_q != CntMax) begin
                        cnt_q  <= cnt_q + 1'b1;
                        wrap_q <= 1'b0;
                    end else begin
                        cnt_q <= '0;
                        if (idx_q == IdxMax) begin
                            idx_q  <= '0;
                            y_q    <= onehot('0);
                            wrap_q <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            y_q    <= onehot(idx_q + 1'b1);
                            wrap_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Idle keeps idx and cnt so the last slot stays observable.
                    y_q    <= '0;
                    wrap_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_onehot_scan.sv
// Directed bench for decoder_onehot_scan across four parameter sets sharing clk/rst.
module tb_decoder_onehot_scan;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decoder_onehot_scan_if #(.AW(3)) if0 ();
    decoder_onehot_scan_if #(.AW(2)) if1 ();
    decoder_onehot_scan_if #(.AW(2)) if2 ();
    decoder_onehot_scan_if #(.AW(2)) if3 ();

    decoder_onehot_scan #(.AW(3), .DIV(4), .LIMIT(5)) u0 (.clk(clk), .rst(rst), .bus(if0));
    decoder_onehot_scan #(.AW(2), .DIV(3), .LIMIT(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
    decoder_onehot_scan #(.AW(2), .DIV(1), .LIMIT(4)) u2 (.clk(clk), .rst(rst), .bus(if2));
    decoder_onehot_scan #(.AW(2), .DIV(2), .LIMIT(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.en = 1'b0; if0.mode = 1'b0; if0.a = '0;
        if1.en = 1'b0; if1.mode = 1'b0; if1.a = '0;
        if2.en = 1'b0; if2.mode = 1'b0; if2.a = '0;
        if3.en = 1'b0; if3.mode = 1'b0; if3.a = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        if0.en = 1'b1; if0.mode = 1'b1;
        if1.en = 1'b1; if1.mode = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if (if0.y !== 8'h00) begin
            fails++; $display("FAIL reset_y0: got %h expected %h", if0.y, 8'h00);
        end
        tests++;
        if (if0.idx !== 3'd0) begin
            fails++; $display("FAIL reset_idx0: got %0d expected %0d", if0.idx, 0);
        end
        tests++;
        if (if0.wrap !== 1'b0) begin
            fails++; $display("FAIL reset_wrap0: got %b expected %b", if0.wrap, 1'b0);
        end
        tests++;
        if (if1.y !== 4'h0) begin
            fails++; $display("FAIL reset_y1: got %h expected %h", if1.y, 4'h0);
        end
        rst = 1'b0;
        repeat (4) tick();
        tests++;
        if (if1.y !== 4'b0010 || if1.idx !== 2'd1) begin
            fails++;
            $display("FAIL pre_async_rst: got y=%b idx=%0d expected y=0010 idx=1", if1.y, if1.idx);
        end
        rst = 1'b1;
        #2;
        tests++;
        if (if1.y !== 4'b0000 || if1.idx !== 2'd0 || if1.wrap !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: got y=%b idx=%0d wrap=%b expected y=0000 idx=0 wrap=0",
                     if1.y, if1.idx, if1.wrap);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_direct();
        logic [7:0] exp_y [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        do_reset();
        if0.en = 1'b1; if0.mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if0.a = 3'(i);
            tick();
            tests++;
            if (if0.y !== exp_y[i] || if0.idx !== 3'(i) || if0.wrap !== 1'b0) begin
                fails++;
                $display("FAIL direct a=%0d: got y=%h idx=%0d wrap=%b expected y=%h idx=%0d wrap=0",
                         i, if0.y, if0.idx, if0.wrap, exp_y[i], i);
            end
        end
        // New address must not appear before the next edge.
        if0.a = 3'd2;
        #2;
        tests++;
        if (if0.y !== 8'h80) begin
            fails++; $display("FAIL direct_latency: got %h expected %h", if0.y, 8'h80);
        end
        tick();
        tests++;
        if (if0.y !== 8'h04) begin
            fails++; $display("FAIL direct_after_edge: got %h expected %h", if0.y, 8'h04);
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] exp_y [19] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                                   4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h1};
        logic [1:0] exp_i [19] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                   2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        logic       exp_w [19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        if1.en = 1'b1; if1.mode = 1'b1;
        for (int c = 0; c < 19; c++) begin
            tick();
            tests++;
            if (if1.y !== exp_y[c] || if1.idx !== exp_i[c] || if1.wrap !== exp_w[c]) begin
                fails++;
                $display("FAIL scan_wrap c=%0d: got y=%b idx=%0d wrap=%b expected y=%b idx=%0d wrap=%b",
                         c, if1.y, if1.idx, if1.wrap, exp_y[c], exp_i[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_div1();
        logic [3:0] exp_y [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        logic       exp_w [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        do_reset();
        if2.en = 1'b1; if2.mode = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            tests++;
            if (if2.y !== exp_y[c] || if2.wrap !== exp_w[c]) begin
                fails++;
                $display("FAIL div1 c=%0d: got y=%b wrap=%b expected y=%b wrap=%b",
                         c, if2.y, if2.wrap, exp_y[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_limit1();
        logic exp_w [7] = '{0, 0, 1, 0, 1, 0, 1};
        do_reset();
        if3.en = 1'b1; if3.mode = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            tests++;
            if (if3.y !== 4'h1 || if3.idx !== 2'd0 || if3.wrap !== exp_w[c]) begin
                fails++;
                $display("FAIL limit1 c=%0d: got y=%b idx=%0d wrap=%b expected y=0001 idx=0 wrap=%b",
                         c, if3.y, if3.idx, if3.wrap, exp_w[c]);
            end
        end
    endtask

    task automatic test_reenable();
        logic [3:0] exp_y [4] = '{4'h1, 4'h1, 4'h1, 4'h2};
        do_reset();
        if1.en = 1'b1; if1.mode = 1'b1;
        repeat (7) tick();
        tests++;
        if (if1.y !== 4'b0100 || if1.idx !== 2'd2) begin
            fails++;
            $display("FAIL reen_at_slot2: got y=%b idx=%0d expected y=0100 idx=2", if1.y, if1.idx);
        end
        if1.en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (if1.y !== 4'b0000 || if1.idx !== 2'd2 || if1.wrap !== 1'b0) begin
                fails++;
                $display("FAIL reen_idle c=%0d: got y=%b idx=%0d wrap=%b expected y=0000 idx=2 wrap=0",
                         c, if1.y, if1.idx, if1.wrap);
            end
        end
        if1.en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++;
            if (if1.y !== exp_y[c]) begin
                fails++;
                $display("FAIL reen_restart c=%0d: got y=%b expected y=%b", c, if1.y, exp_y[c]);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        if1.en = 1'b1; if1.mode = 1'b1; if1.a = 2'd3;
        repeat (9) tick();
        // Last cycle of slot LIMIT-1: staying in scan would wrap on the next edge.
        if1.mode = 1'b0;
        tick();
        tests++;
        if (if1.y !== 4'b1000 || if1.idx !== 2'd3 || if1.wrap !== 1'b0) begin
            fails++;
            $display("FAIL mode_to_direct: got y=%b idx=%0d wrap=%b expected y=1000 idx=3 wrap=0",
                     if1.y, if1.idx, if1.wrap);
        end
        if1.mode = 1'b1;
        tick();
        tests++;
        if (if1.y !== 4'b0001 || if1.idx !== 2'd0 || if1.wrap !== 1'b0) begin
            fails++;
            $display("FAIL mode_to_scan: got y=%b idx=%0d wrap=%b expected y=0001 idx=0 wrap=0",
                     if1.y, if1.idx, if1.wrap);
        end
        repeat (2) tick();
        tests++;
        if (if1.y !== 4'b0001) begin
            fails++; $display("FAIL mode_scan_hold: got %b expected %b", if1.y, 4'b0001);
        end
        tick();
        tests++;
        if (if1.y !== 4'b0010 || if1.idx !== 2'd1) begin
            fails++;
            $display("FAIL mode_scan_step: got y=%b idx=%0d expected y=0010 idx=1", if1.y, if1.idx);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_direct();
        test_scan_wrap();
        test_div1();
        test_limit1();
        test_reenable();
        test_mode_switch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
